// File: rtl/bus_dma_master.sv
// Word-copy DMA initiator for the shared SoC memory bus.
// Uses request/grant arbitration and a one-cycle registered-read bus.
module bus_dma_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] srcAddr,
    input  logic [ADDR_WIDTH-1:0] dstAddr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [LEN_WIDTH-1:0]  wordsRemaining,
    output logic                  busRequest,
    input  logic                  busGrant,
    output logic                  busLock,
    output logic [ADDR_WIDTH-1:0] busAddress,
    output logic                  busWriteEnable,
    output logic [DATA_WIDTH-1:0] busDataOut,
    input  logic [DATA_WIDTH-1:0] busDataIn
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD,
        CAP,
        WR,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);
    localparam logic [LEN_WIDTH-1:0]  ONE       = LEN_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] src;
    logic [ADDR_WIDTH-1:0] dst;
    logic [LEN_WIDTH-1:0]  count;
    logic [DATA_WIDTH-1:0] buffer;
    logic                  aborted_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            count     <= '0;
            buffer    <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        src   <= srcAddr & WORD_MASK;
                        dst   <= dstAddr & WORD_MASK;
                        count <= len;
                        state <= (len == '0) ? DONE : REQ;
                    end
                end
                REQ: begin
                    if (abort) begin
                        state     <= IDLE;
                        aborted_q <= 1'b1;
                    end else if (busGrant) begin
                        state <= RD;
                    end
                end
                RD: begin
                    if (abort) begin
                        state     <= IDLE;
                        aborted_q <= 1'b1;
                    end else begin
                        state <= CAP;
                    end
                end
                CAP: begin
                    buffer <= busDataIn;
                    if (abort) begin
                        state     <= IDLE;
                        aborted_q <= 1'b1;
                    end else begin
                        state <= WR;
                    end
                end
                WR: begin
                    // The write in flight always retires, even on abort
                    src   <= src + WORD_STEP;
                    dst   <= dst + WORD_STEP;
                    count <= count - ONE;
                    if (abort) begin
                        state     <= IDLE;
                        aborted_q <= 1'b1;
                    end else if (count == ONE) begin
                        state <= DONE;
                    end else if (busGrant) begin
                        state <= RD;
                    end else begin
                        state <= REQ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic active;
    logic reading;
    logic writing;

    assign reading = (state == RD) || (state == CAP);
    assign writing = (state == WR);
    assign active  = reading || writing || (state == REQ);

    assign busy           = active;
    assign busRequest     = active;
    assign busLock        = reading || writing;
    assign done           = (state == DONE);
    assign aborted        = aborted_q;
    assign wordsRemaining = count;
    assign busWriteEnable = writing;
    assign busDataOut     = writing ? buffer : '0;
    assign busAddress     = reading ? src : (writing ? dst : '0);

endmodule

// File: tb/tb_bus_dma_master.sv
// Self-checking bench for bus_dma_master with a registered-read memory.
// Table of whole transfers plus grant-stall, abort and reset sequences.
module tb_bus_dma_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] srcAddr;
    logic [31:0] dstAddr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] wordsRemaining;
    logic        busRequest;
    logic        busGrant;
    logic        busLock;
    logic [31:0] busAddress;
    logic        busWriteEnable;
    logic [31:0] busDataOut;
    logic [31:0] busDataIn = '0;

    bus_dma_master dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .srcAddr(srcAddr),
        .dstAddr(dstAddr),
        .len(len),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .wordsRemaining(wordsRemaining),
        .busRequest(busRequest),
        .busGrant(busGrant),
        .busLock(busLock),
        .busAddress(busAddress),
        .busWriteEnable(busWriteEnable),
        .busDataOut(busDataOut),
        .busDataIn(busDataIn)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
    endfunction

    typedef struct {
        int          c;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic [31:0] mem [logic [31:0]];
    wr_t         wlog [$];

    always @(posedge clk) begin
        busDataIn <= mem.exists(busAddress) ? mem[busAddress] : pat(busAddress);
        if (busWriteEnable) begin
            mem[busAddress] = busDataOut;
            wlog.push_back('{cyc, busAddress, busDataOut});
        end
    end

    int pass = 0;
    int total = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] n;
        logic [31:0] src_al;
        logic [31:0] dst_al;
        int          lat;
    } vec_t;

    vec_t vec [5];

    task automatic wait_done(input int budget, output int lat, input int s);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done) check("done_timeout", 0, 1);
        lat = cyc - s;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   s;
        int   lat;
        int   k;
        logic any_req;
        v = vec[i];
        wlog.delete();
        @(negedge clk);
        srcAddr = v.src;
        dstAddr = v.dst;
        len     = v.n;
        start   = 1'b1;
        s       = cyc;
        @(negedge clk);
        start   = 1'b0;
        check($sformatf("v%0d_busy1", i), busy, v.n != 0);
        any_req = 1'b0;
        k = 0;
        while (!done && k < 300) begin
            any_req |= busRequest;
            @(negedge clk);
            k++;
        end
        if (!done) check($sformatf("v%0d_timeout", i), 0, 1);
        lat = cyc - s;
        check($sformatf("v%0d_latency", i), lat, v.lat);
        check($sformatf("v%0d_busy_at_done", i), busy, 0);
        check($sformatf("v%0d_remaining", i), wordsRemaining, 0);
        check($sformatf("v%0d_any_req", i), any_req, v.n != 0);
        check($sformatf("v%0d_nwrites", i), wlog.size(), v.n);
        for (int j = 0; j < wlog.size() && j < int'(v.n); j++) begin
            check($sformatf("v%0d_w%0d_addr", i, j), wlog[j].a,
                  v.dst_al + 32'(4 * j));
            check($sformatf("v%0d_w%0d_data", i, j), wlog[j].d,
                  pat(v.src_al + 32'(4 * j)));
            check($sformatf("v%0d_w%0d_cyc", i, j), wlog[j].c - s, 4 + 3 * j);
        end
        @(negedge clk);
        check($sformatf("v%0d_done_1cyc", i), done, 0);
    endtask

    initial begin
        int s;
        int lat;
        int k;
        logic seen;

        vec[0] = '{32'h0001_0000, 32'h0001_0100, 16'd4,
                   32'h0001_0000, 32'h0001_0100, 14};
        vec[1] = '{32'h0002_0000, 32'h0002_0800, 16'd1,
                   32'h0002_0000, 32'h0002_0800, 5};
        vec[2] = '{32'h0003_0000, 32'h0003_0400, 16'd0,
                   32'h0003_0000, 32'h0003_0400, 1};
        vec[3] = '{32'h0001_0003, 32'h0004_0002, 16'd2,
                   32'h0001_0000, 32'h0004_0000, 8};
        vec[4] = '{32'hFFFF_FFF8, 32'h0005_0000, 16'd3,
                   32'hFFFF_FFF8, 32'h0005_0000, 11};

        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        srcAddr  = '0;
        dstAddr  = '0;
        len      = '0;
        busGrant = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_req", busRequest, 0);
        check("rst_lock", busLock, 0);
        check("rst_addr", busAddress, 0);
        check("rst_we", busWriteEnable, 0);
        check("rst_dout", busDataOut, 0);
        check("rst_remaining", wordsRemaining, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(i);

        // Grant stalls before word 1 and after word 2
        wlog.delete();
        busGrant = 1'b0;
        srcAddr  = 32'h0006_0000;
        dstAddr  = 32'h0006_1000;
        len      = 16'd3;
        start    = 1'b1;
        s        = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 5; j++) begin
            check("stall0_req", busRequest, 1);
            check("stall0_addr", busAddress, 0);
            check("stall0_we", busWriteEnable, 0);
            check("stall0_lock", busLock, 0);
            if (j < 4) @(negedge clk);
        end
        busGrant = 1'b1;
        k = 0;
        while (!(busWriteEnable && wlog.size() == 1) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("stall1_reach_wr2", busWriteEnable && wlog.size() == 1, 1);
        busGrant = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall1_req", busRequest, 1);
            check("stall1_addr", busAddress, 0);
            check("stall1_lock", busLock, 0);
        end
        check("stall1_remaining", wordsRemaining, 1);
        busGrant = 1'b1;
        wait_done(50, lat, s);
        check("stall_nwrites", wlog.size(), 3);
        for (int j = 0; j < wlog.size() && j < 3; j++) begin
            check("stall_addr", wlog[j].a, 32'h0006_1000 + 32'(4 * j));
            check("stall_data", wlog[j].d, pat(32'h0006_0000 + 32'(4 * j)));
        end
        @(negedge clk);

        // Abort in the CAP cycle of word 3
        wlog.delete();
        srcAddr = 32'h0007_0000;
        dstAddr = 32'h0007_1000;
        len     = 16'd8;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_pre_writes", wlog.size(), 2);
        check("abort_pre_lock", busLock, 1);
        check("abort_pre_we", busWriteEnable, 0);
        check("abort_pre_remaining", wordsRemaining, 6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_pulse", aborted, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_req", busRequest, 0);
        check("abort_remaining", wordsRemaining, 6);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen |= done | aborted | busWriteEnable;
        end
        check("abort_quiet_after", seen, 0);
        check("abort_writes", wlog.size(), 2);

        // Simultaneous start and abort in IDLE: start wins
        wlog.delete();
        srcAddr = 32'h0009_0000;
        dstAddr = 32'h0009_1000;
        len     = 16'd1;
        start   = 1'b1;
        abort   = 1'b1;
        s       = cyc;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", busy, 1);
        check("sa_aborted", aborted, 0);
        wait_done(50, lat, s);
        check("sa_latency", lat, 5);
        check("sa_nwrites", wlog.size(), 1);
        if (wlog.size() > 0) check("sa_data", wlog[0].d, pat(32'h0009_0000));
        @(negedge clk);

        // Reset during the first WR cycle
        srcAddr = 32'h0008_0000;
        dstAddr = 32'h0008_1000;
        len     = 16'd4;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rwr_in_wr", busWriteEnable, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rwr_busy", busy, 0);
        check("rwr_req", busRequest, 0);
        check("rwr_lock", busLock, 0);
        check("rwr_addr", busAddress, 0);
        check("rwr_we", busWriteEnable, 0);
        check("rwr_dout", busDataOut, 0);
        check("rwr_remaining", wordsRemaining, 0);
        reset = 1'b0;
        run_vec(0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
